apb_timer_slave: RTL and testbench



---
 rtl/apb_timer_slave.sv | 117 +++++++++++
 tb/tb_apb_timer_slave.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB timer: prescaled down-counter with auto-reload/one-shot,
// sticky expiry flag and level interrupt.
module apb_timer_slave #(
  parameter int CNT_WIDTH = 32,
  parameter int PRE_WIDTH = 8
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LOAD   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic                 ctrl_en;
  logic                 ctrl_auto;
  logic                 ctrl_irq_en;
  logic [PRE_WIDTH-1:0] ctrl_pre;
  logic [PRE_WIDTH-1:0] pre_cnt;
  logic [CNT_WIDTH-1:0] load_val;
  logic [CNT_WIDTH-1:0] count_val;
  logic                 expired;

  logic        wr_acc;
  logic        rd_setup;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_status;
  logic        tick;
  logic        tick_eff;
  logic        set_exp;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign wr_acc    = Psel & Penable & Pwrite;
  assign rd_setup  = Psel & ~Penable & ~Pwrite;
  assign wr_ctrl   = wr_acc & (Paddr[3:2] == ADDR_CTRL);
  assign wr_load   = wr_acc & (Paddr[3:2] == ADDR_LOAD);
  assign wr_status = wr_acc & (Paddr[3:2] == ADDR_STATUS);

  assign unused_addr_bits = ^{Paddr[31:4], Paddr[1:0]};

  assign tick = ctrl_en & (pre_cnt == ctrl_pre);

  // A LOAD write or a CTRL write that clears EN suppresses the coincident tick entirely.
  assign tick_eff = tick & ~wr_load & ~(wr_ctrl & ~Pwdata[0]);
  assign set_exp  = tick_eff & (count_val == '0);

  assign irq = expired & ctrl_irq_en;

  always_comb begin
    rd_mux = '0;
    case (Paddr[3:2])
      ADDR_CTRL: begin
        rd_mux[0]              = ctrl_en;
        rd_mux[1]              = ctrl_auto;
        rd_mux[2]              = ctrl_irq_en;
        rd_mux[8 +: PRE_WIDTH] = ctrl_pre;
      end
      ADDR_LOAD:   rd_mux[CNT_WIDTH-1:0] = load_val;
      ADDR_COUNT:  rd_mux[CNT_WIDTH-1:0] = count_val;
      ADDR_STATUS: rd_mux[0]             = expired;
      default:     rd_mux                = '0;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      ctrl_en     <= 1'b0;
      ctrl_auto   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_pre    <= '0;
      pre_cnt     <= '0;
      load_val    <= '0;
      count_val   <= '0;
      expired     <= 1'b0;
      Prdata      <= '0;
    end else begin
      if (!ctrl_en || tick) pre_cnt <= '0;
      else                  pre_cnt <= pre_cnt + 1'b1;

      if (tick_eff) begin
        if (count_val != '0)  count_val <= count_val - 1'b1;
        else if (ctrl_auto)   count_val <= load_val;
        else                  ctrl_en   <= 1'b0;
      end

      // New expiry beats a coincident write-1-to-clear.
      expired <= set_exp | (expired & ~(wr_status & Pwdata[0]));

      if (wr_ctrl) begin
        ctrl_en     <= Pwdata[0];
        ctrl_auto   <= Pwdata[1];
        ctrl_irq_en <= Pwdata[2];
        ctrl_pre    <= Pwdata[8 +: PRE_WIDTH];
        if (!ctrl_en && Pwdata[0]) pre_cnt <= '0;
      end

      if (wr_load) begin
        load_val  <= Pwdata[CNT_WIDTH-1:0];
        count_val <= Pwdata[CNT_WIDTH-1:0];
        pre_cnt   <= '0;
      end

      Prdata <= rd_setup ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: register access table plus timer sequences.
module tb_apb_timer_slave;

  logic        Hclk;
  logic        Hreset;
  logic        Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        irq;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_LOAD   = 32'h4;
  localparam logic [31:0] A_COUNT  = 32'h8;
  localparam logic [31:0] A_STATUS = 32'hC;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[17];
  int   n_vec;
  int   n_miss;

  apb_timer_slave #(.CNT_WIDTH(32), .PRE_WIDTH(8)) dut (
    .Hclk    (Hclk),
    .Hreset  (Hreset),
    .Psel    (Psel),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Prdata  (Prdata),
    .irq     (irq)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Tasks are entered 1 time unit after a rising edge and return likewise.
  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = a; Pwdata = d;
    @(posedge Hclk); #1 Penable = 1'b1;
    @(posedge Hclk); #1 Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = a;
    @(posedge Hclk); #1 Penable = 1'b1;
    @(negedge Hclk); d = Prdata;
    @(posedge Hclk); #1 Psel = 1'b0; Penable = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    n_vec  = 0;
    n_miss = 0;
    Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
    Hreset = 1'b1;

    vt[0]  = '{1'b0, A_CTRL,     32'h0,        32'h0};
    vt[1]  = '{1'b0, A_LOAD,     32'h0,        32'h0};
    vt[2]  = '{1'b0, A_COUNT,    32'h0,        32'h0};
    vt[3]  = '{1'b0, A_STATUS,   32'h0,        32'h0};
    vt[4]  = '{1'b1, A_LOAD,     32'hDEADBEEF, 32'h0};
    vt[5]  = '{1'b0, A_LOAD,     32'h0,        32'hDEADBEEF};
    vt[6]  = '{1'b0, A_COUNT,    32'h0,        32'hDEADBEEF};
    vt[7]  = '{1'b1, A_CTRL,     32'hFFFFFFF6, 32'h0};
    vt[8]  = '{1'b0, A_CTRL,     32'h0,        32'h0000FF06};
    vt[9]  = '{1'b1, 32'h104,    32'h55,       32'h0};
    vt[10] = '{1'b0, A_LOAD,     32'h0,        32'h55};
    vt[11] = '{1'b0, A_COUNT,    32'h0,        32'h55};
    vt[12] = '{1'b1, A_CTRL,     32'h0,        32'h0};
    vt[13] = '{1'b1, A_LOAD,     32'h0,        32'h0};
    vt[14] = '{1'b0, A_CTRL,     32'h0,        32'h0};
    vt[15] = '{1'b1, A_STATUS,   32'hFFFFFFFE, 32'h0};
    vt[16] = '{1'b0, A_STATUS,   32'h0,        32'h0};

    repeat (2) @(posedge Hclk);
    #1 Hreset = 1'b0;
    @(negedge Hclk);
    chk("reset_prdata", Prdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    @(posedge Hclk); #1;

    for (int i = 0; i < 17; i++) begin
      if (vt[i].wr) apb_wr(vt[i].addr, vt[i].data);
      else begin
        apb_rd(vt[i].addr, r);
        chk($sformatf("vec%0d", i), r, vt[i].exp);
      end
    end

    // Auto-reload, PRESCALE=0: enable commits at E0, expiries at E4, E8, E12.
    apb_wr(A_LOAD, 32'd3);
    apb_wr(A_CTRL, 32'h7);
    apb_rd(A_COUNT, r);  chk("ar_count_e0", r, 32'd3);
    apb_rd(A_COUNT, r);  chk("ar_count_e2", r, 32'd1);
    apb_rd(A_STATUS, r); chk("ar_status_e4", r, 32'd1);
    apb_rd(A_COUNT, r);  chk("ar_count_e6", r, 32'd1);
    chk("ar_irq_set", {31'b0, irq}, 32'd1);
    apb_wr(A_STATUS, 32'h1);
    for (int k = 10; k <= 12; k++) begin
      @(negedge Hclk);
      chk($sformatf("ar_irq_e%0d", k), {31'b0, irq}, (k == 12) ? 32'd1 : 32'd0);
    end
    @(posedge Hclk); #1;
    apb_wr(A_CTRL, 32'h0);
    apb_wr(A_STATUS, 32'h1);

    // One-shot, PRESCALE=2: ticks at E3, E6, E9; expiry at E9.
    apb_wr(A_LOAD, 32'd2);
    apb_wr(A_CTRL, 32'h205);
    for (int k = 0; k <= 9; k++) begin
      @(negedge Hclk);
      chk($sformatf("os_irq_e%0d", k), {31'b0, irq}, (k == 9) ? 32'd1 : 32'd0);
    end
    @(posedge Hclk); #1;
    apb_rd(A_CTRL, r);  chk("os_ctrl_en_clr", r, 32'h204);
    apb_rd(A_COUNT, r); chk("os_count_hold", r, 32'h0);
    apb_wr(A_STATUS, 32'h1);
    @(negedge Hclk);
    chk("os_irq_cleared", {31'b0, irq}, 32'd0);
    @(posedge Hclk); #1;
    apb_rd(A_STATUS, r); chk("os_status_cleared", r, 32'h0);

    // LOAD=0, PRESCALE=0 expires every cycle, so the W1C always collides with a set.
    apb_wr(A_LOAD, 32'd0);
    apb_wr(A_CTRL, 32'h7);
    apb_wr(A_STATUS, 32'h1);
    apb_rd(A_STATUS, r); chk("w1c_vs_set", r, 32'h1);
    apb_wr(A_CTRL, 32'h0);
    apb_wr(A_STATUS, 32'h1);
    apb_rd(A_STATUS, r); chk("w1c_idle", r, 32'h0);

    // Read while counting, ignored COUNT write, Psel=0 write, then reset mid-count.
    apb_wr(A_LOAD, 32'd100);
    apb_wr(A_CTRL, 32'h3);
    apb_rd(A_COUNT, r); chk("cnt_setup_value", r, 32'd100);
    apb_wr(A_COUNT, 32'hFFFF);
    apb_rd(A_COUNT, r); chk("cnt_write_ignored", r, 32'd96);
    Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b1; Paddr = A_LOAD; Pwdata = 32'h1234;
    @(posedge Hclk); #1 Penable = 1'b1;
    @(posedge Hclk); #1 Penable = 1'b0; Pwrite = 1'b0;
    apb_rd(A_LOAD, r); chk("nosel_write_ignored", r, 32'd100);
    @(negedge Hclk);
    chk("prdata_idle", Prdata, 32'h0);
    @(posedge Hclk); #1;
    apb_rd(A_COUNT, r); chk("cnt_still_running", r, 32'd89);
    Hreset = 1'b1;
    @(posedge Hclk); #1 Hreset = 1'b0;
    chk("rst_irq", {31'b0, irq}, 32'h0);
    apb_rd(A_COUNT, r); chk("rst_count", r, 32'h0);
    apb_rd(A_CTRL, r);  chk("rst_ctrl", r, 32'h0);
    apb_rd(A_LOAD, r);  chk("rst_load", r, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
